lsu_rmw: RTL

- Load/store initiator sitting between the CPU MEM stage and the word-only data memory (7-bit word address, combinational read, synchronous write).
- Converts byte, halfword and word loads/stores into word accesses.
- Sub-word stores use a read-modify-write sequence.
- Returns sign- or zero-extended load data through a req/ready/done handshake.

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_lane.sv | 67 ++++++
 rtl/lsu_rmw.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Shared encodings for the load/store RMW initiator: access size
//             codes, FSM state type, memory word-address width and helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam int DM_AW = 7;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } lsu_state_e;

    // Byte and halfword stores need a read-modify-write; size 11 acts as word.
    function automatic logic is_subword(input logic [1:0] size);
        return (size == SZ_BYTE) || (size == SZ_HALF);
    endfunction

    // Natural alignment check used only when the misalign trap is built in.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic r;
        case (size)
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = lo[0];
            default: r = (lo != 2'b00);
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_lane
//  Purpose  : Combinational little-endian lane logic. Selects and extends the
//             load value from a memory word, and merges store data into the
//             selected byte/halfword lane of that word.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection, sign/zero extension and lane replacement.
    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half   = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
        o_load   = i_word;
        o_merged = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_load   = {{24{~i_uns & w_byte[7]}}, w_byte};
                o_merged = i_word;
                case (i_addr_lo)
                    2'd0:    o_merged[7:0]   = i_wdata[7:0];
                    2'd1:    o_merged[15:8]  = i_wdata[7:0];
                    2'd2:    o_merged[23:16] = i_wdata[7:0];
                    default: o_merged[31:24] = i_wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                o_load   = {{16{~i_uns & w_half[15]}}, w_half};
                o_merged = i_word;
                if (i_addr_lo[1]) begin
                    o_merged[31:16] = i_wdata[15:0];
                end else begin
                    o_merged[15:0]  = i_wdata[15:0];
                end
            end
            SZ_WORD: begin
                o_load   = i_word;
                o_merged = i_wdata;
            end
            default: begin
                o_load   = i_word;
                o_merged = i_wdata;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_rmw.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_rmw
//  Purpose  : Load/store initiator between the CPU MEM stage and a word-only
//             data memory. Sub-word stores are done as read-modify-write.
//             Optional macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word
//             accesses complete without touching memory and raise err.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int AW = DM_AW,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic          uns,
    input  logic [31:0]   addr,
    input  logic [DW-1:0] wdata,
    output logic          ready,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          dm_wr,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_din,
    input  logic [DW-1:0] dm_dout
);

    lsu_state_e    state_q, state_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          dm_wr_q, dm_wr_d;
    logic [AW-1:0] dm_addr_q, dm_addr_d;
    logic [DW-1:0] dm_din_q, dm_din_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic [DW-1:0] w_load;
    logic [DW-1:0] w_merged;
    logic          w_trap_in;
    logic          w_trap_q;
    logic          w_unused_addr;

    // Upper address bits wrap into the memory and are intentionally dropped.
    assign w_unused_addr = ^addr[31:AW+2];

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_trap_in = is_misaligned(size, addr[1:0]);
    assign w_trap_q  = is_misaligned(size_q, addr_q[1:0]);
`else
    assign w_trap_in = 1'b0;
    assign w_trap_q  = 1'b0;
`endif

    lsu_lane u_lane (
        .i_word    (dm_dout),
        .i_addr_lo (addr_q[1:0]),
        .i_size    (size_q),
        .i_uns     (uns_q),
        .i_wdata   (wdata_q),
        .o_load    (w_load),
        .o_merged  (w_merged)
    );

    // Next-state and registered-output computation for the access sequence.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        size_d    = size_q;
        uns_d     = uns_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ready_d   = ready_q;
        done_d    = done_q;
        err_d     = err_q;
        dm_wr_d   = dm_wr_q;
        dm_addr_d = dm_addr_q;
        dm_din_d  = dm_din_q;
        rdata_d   = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d      = we;
                    size_d    = size;
                    uns_d     = uns;
                    addr_d    = addr[AW+1:0];
                    wdata_d   = wdata;
                    ready_d   = 1'b0;
                    dm_addr_d = addr[AW+1:2];
                    // Word stores write during ACCESS, so data must be ready then.
                    dm_wr_d   = we && !is_subword(size) && !w_trap_in;
                    dm_din_d  = wdata;
                    state_d   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                dm_wr_d = 1'b0;
                if (w_trap_q) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (!we_q) begin
                    rdata_d = w_load;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (is_subword(size_q)) begin
                    dm_wr_d  = 1'b1;
                    dm_din_d = w_merged;
                    state_d  = ST_WRITE;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_WRITE: begin
                dm_wr_d = 1'b0;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d    = 1'b0;
                err_d     = 1'b0;
                ready_d   = 1'b1;
                dm_addr_d = '0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            dm_wr_q   <= 1'b0;
            dm_addr_q <= '0;
            dm_din_q  <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            err_q     <= err_d;
            dm_wr_q   <= dm_wr_d;
            dm_addr_q <= dm_addr_d;
            dm_din_q  <= dm_din_d;
            rdata_q   <= rdata_d;
        end
    end

    assign ready   = ready_q;
    assign done    = done_q;
    assign err     = err_q;
    assign rdata   = rdata_q;
    assign dm_addr = dm_addr_q;
    assign dm_din  = dm_din_q;
    // A reset arriving mid-RMW must suppress the pending write immediately.
    assign dm_wr   = dm_wr_q & ~rst;

endmodule
`default_nettype wire
